// File: rtl/vic_pkg.sv
// ---------------------------------------------------------------------------
// vic_pkg -- constants and types shared by the Vic interrupt controller and
// the external interrupt conditioner (ext_irq_cond).
//   NUM_EXT          number of external interrupt lines
//   CFG_AW / CFG_DW  configuration address / data widths
//   CFG_ADDR_THRESH  configuration address of the filter threshold register
//   THRESH_RST_DEF   reset value of the filter threshold
// ---------------------------------------------------------------------------
package vic_pkg;

    localparam int NUM_EXT         = 31;
    localparam int CFG_AW          = 5;
    localparam int CFG_DW          = 4;
    localparam int CFG_ADDR_THRESH = 31;

    localparam logic [CFG_DW-1:0] THRESH_RST_DEF = 4'd2;

    typedef logic [CFG_AW-1:0] cfg_addr_t;
    typedef logic [CFG_DW-1:0] cfg_data_t;

endpackage

// File: rtl/ext_irq_cond_if.sv
// ---------------------------------------------------------------------------
// ext_irq_cond_if -- configuration write bus of ext_irq_cond.
//   we    write strobe, one write per cycle with we=1 (no back-pressure)
//   addr  0..NUM_EXT-1 line enable, CFG_ADDR_THRESH threshold
//   data  write data (bit 0 for enables, all bits for the threshold)
// Modports: master drives the bus, slave receives it.
// ---------------------------------------------------------------------------
interface ext_irq_cond_if;
    import vic_pkg::*;

    logic      we;
    cfg_addr_t addr;
    cfg_data_t data;

    modport master (output we, output addr, output data);
    modport slave  (input  we, input  addr, input  data);

endinterface

// File: rtl/irq_line_filter.sv
// ---------------------------------------------------------------------------
// irq_line_filter -- two-flop synchronizer plus glitch filter for one line.
// Build option: IRQ_FILTER_EN enables the mismatch counter; without it the
// stable value simply follows the synchronizer output.
//   clk       clock
//   rst       synchronous active-high reset
//   i_raw     asynchronous raw interrupt line
//   i_thresh  number of extra mismatching cycles required before accepting
//   o_stable  filtered stable level
// ---------------------------------------------------------------------------
module irq_line_filter
    import vic_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_raw,
    input  cfg_data_t i_thresh,
    output logic      o_stable
);

    logic r_sync1;
    logic r_sync2;
    logic r_s;

`ifdef IRQ_FILTER_EN
    cfg_data_t r_cnt;

    // A new level is accepted only after it has disagreed with the stable
    // value for threshold+1 consecutive cycles; any agreement restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_s     <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_s) begin
                r_cnt <= '0;
            end else if (r_cnt >= i_thresh) begin
                r_s   <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end
`else
    // Threshold is accepted but has no effect in the unfiltered build.
    logic w_unused_thresh;
    assign w_unused_thresh = ^i_thresh;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_s     <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_s     <= r_sync2;
        end
    end
`endif

    assign o_stable = r_s;

endmodule

// File: rtl/ext_irq_cond.sv
// ---------------------------------------------------------------------------
// ext_irq_cond -- conditions the raw external interrupt lines for Vic:
// synchronizes and filters each line, masks it with a per-line enable and
// pulses o_change when the conditioned vector changes.
// Build option: IRQ_FILTER_EN (counter filter in irq_line_filter).
//   clk         clock
//   rst         synchronous active-high reset
//   i_irq_raw   raw asynchronous interrupt lines
//   i_cfg_we    configuration write strobe
//   i_cfg_addr  0..NUM_EXT-1 enable bit, 31 threshold
//   i_cfg_data  configuration write data
//   o_ext       conditioned lines (stable AND enable)
//   o_change    one-cycle pulse, one cycle after any o_ext change
// ---------------------------------------------------------------------------
module ext_irq_cond
    import vic_pkg::*;
#(
    parameter int        NUM_EXT    = vic_pkg::NUM_EXT,
    parameter cfg_data_t THRESH_RST = THRESH_RST_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EXT-1:0] i_irq_raw,
    input  logic               i_cfg_we,
    input  cfg_addr_t          i_cfg_addr,
    input  cfg_data_t          i_cfg_data,
    output logic [NUM_EXT-1:0] o_ext,
    output logic               o_change
);

    logic [NUM_EXT-1:0] r_enable;
    cfg_data_t          r_thresh;
    logic [NUM_EXT-1:0] r_ext_q;
    logic               r_change;
    logic [NUM_EXT-1:0] w_stable;
    logic [NUM_EXT-1:0] w_ext;

    for (genvar g = 0; g < NUM_EXT; g++) begin : g_line
        irq_line_filter u_filter (
            .clk      (clk),
            .rst      (rst),
            .i_raw    (i_irq_raw[g]),
            .i_thresh (r_thresh),
            .o_stable (w_stable[g])
        );
    end

    // Masked lines keep filtering, so re-enabling shows the current level.
    assign w_ext = w_stable & r_enable;
    assign o_ext = w_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable <= '1;
            r_thresh <= THRESH_RST;
        end else if (i_cfg_we) begin
            if (int'(i_cfg_addr) < NUM_EXT) begin
                r_enable[i_cfg_addr] <= i_cfg_data[0];
            end else if (i_cfg_addr == cfg_addr_t'(CFG_ADDR_THRESH)) begin
                r_thresh <= i_cfg_data;
            end
        end
    end

    // r_ext_q holds last cycle's o_ext; any difference, on one line or many,
    // yields a single registered pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext_q  <= '0;
            r_change <= 1'b0;
        end else begin
            r_ext_q  <= w_ext;
            r_change <= |(w_ext ^ r_ext_q);
        end
    end

    assign o_change = r_change;

endmodule
